// File: rtl/avr_tx_fifo.sv
// Byte FIFO feeding the AVR serial transmitter; drains one byte per new_data/busy handshake.
// State | meaning: S_IDLE = may pop when data is queued and tx is free; S_HOLD = cover busy lag.
module avr_tx_fifo #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_tx_busy,
    output logic                  o_tx_new_data,
    output logic [7:0]            o_tx_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_tx_new_data;
    logic [7:0]            r_tx_data;
    logic                  w_wr_accept;
    logic                  w_pop;

    assign o_full        = (r_count == C_FULL);
    assign o_empty       = (r_count == '0);
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;
    assign o_tx_new_data = r_tx_new_data;
    assign o_tx_data     = r_tx_data;

    // full is taken from the pre-edge count, so a same-edge pop never frees a slot for this write
    assign w_wr_accept = i_wr_en && !o_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_tx_new_data <= 1'b0;
            r_tx_data     <= 8'h00;
        end else begin
            r_overflow    <= i_wr_en && o_full;
            r_tx_new_data <= w_pop;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_tx_fifo.sv
// Directed bench for avr_tx_fifo with a CLK_PER_BIT=4 transmitter model and serial receiver.
module tb_avr_tx_fifo;
    localparam int AW  = 4;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tb_busy = 1'b0;
    logic          full, empty, ovf, nd;
    logic [AW:0]   count;
    logic [7:0]    txd;
    logic          tx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    avr_tx_fifo #(.ADDR_WIDTH(AW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_overflow    (ovf),
        .i_tx_busy     (tx_busy),
        .o_tx_new_data (nd),
        .o_tx_data     (txd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // transmitter model: busy is registered, rising one cycle after new_data is sampled
    logic       m_busy = 1'b0;
    logic [9:0] m_sh = 10'h3FF;
    int         m_bit = 0;
    int         m_cnt = 0;
    logic       tx_line;

    assign tx_busy = m_busy | tb_busy;
    assign tx_line = m_busy ? m_sh[m_bit] : 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_bit  <= 0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (nd) begin
                m_sh   <= {1'b1, txd, 1'b0};
                m_busy <= 1'b1;
                m_bit  <= 0;
                m_cnt  <= 0;
            end
        end else if (m_cnt == CPB-1) begin
            m_cnt <= 0;
            if (m_bit == 9) m_busy <= 1'b0;
            else            m_bit  <= m_bit + 1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // serial receiver, samples mid-bit
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    int         rx_bit = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_n = 0;

    always @(posedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (!tx_line) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
                rx_bit <= 0;
            end
        end else if (rx_cnt != 0) begin
            rx_cnt <= rx_cnt - 1;
        end else begin
            rx_cnt <= CPB-1;
            rx_bit <= rx_bit + 1;
            if (rx_bit == 0) chk("rx_start", tx_line, 1'b0);
            if (rx_bit >= 1 && rx_bit <= 8) rx_sh[rx_bit-1] <= tx_line;
            if (rx_bit == 9) begin
                rx_act <= 1'b0;
                rx_n++;
                chk("rx_stop", tx_line, 1'b1);
                chk("rx_expected_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("rx_order", rx_sh, exp_q.pop_front());
            end
        end
    end

    // protocol and count monitors
    logic prev_nd = 1'b0;
    logic prev_busy = 1'b0;
    bit   mon_cnt_en = 1'b0;
    int   wr_cnt = 0;
    int   pop_cnt = 0;

    always @(negedge clk) begin
        if (prev_nd) chk("nd_back_to_back", nd, 1'b0);
        if (nd)      chk("nd_after_busy_low", prev_busy, 1'b0);
        if (mon_cnt_en) begin
            if (nd) pop_cnt++;
            chk("count_track", count, wr_cnt - pop_cnt);
        end
        prev_nd   = nd;
        prev_busy = tx_busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        tb_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic burst(input logic [7:0] first, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(first + i);
            tick();
            if (push) exp_q.push_back(8'(first + i));
            wr_cnt++;
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m_busy || !empty) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_empty", empty, 1'b1);
        chk("drain_count", count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int room;
        int sizes[9] = '{3, 7, 1, 5, 8, 2, 6, 4, 4};
        logic [7:0] v;

        // reset values
        do_reset();
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_nd", nd, 1'b0);
        chk("rst_txd", txd, 8'h00);
        chk("rst_ovf", ovf, 1'b0);

        // single write latency
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        exp_q.push_back(8'hA5);
        chk("t1_empty_low", empty, 1'b0);
        chk("t1_count1", count, 1);
        chk("t1_nd_early", nd, 1'b0);
        tick();
        chk("t1_nd", nd, 1'b1);
        chk("t1_txd", txd, 8'hA5);
        chk("t1_count0", count, 0);
        tick();
        chk("t1_nd_one_cycle", nd, 1'b0);
        chk("t1_txd_hold", txd, 8'hA5);
        wait_drain(200);

        // 16-byte burst with transmitter held off, then drain through serial line
        do_reset();
        base = rx_n;
        tb_busy = 1'b1;
        burst(8'h01, 16, 1'b1);
        chk("t2_full", full, 1'b1);
        chk("t2_count", count, 16);
        tb_busy = 1'b0;
        wait_drain(2000);
        chk("t2_frames", rx_n - base, 16);

        // overflow on 17th write while blocked
        base = rx_n;
        tb_busy = 1'b1;
        burst(8'h20, 16, 1'b1);
        chk("t3_count16", count, 16);
        chk("t3_ovf_pre", ovf, 1'b0);
        burst(8'h30, 1, 1'b0);
        chk("t3_ovf", ovf, 1'b1);
        chk("t3_count_kept", count, 16);
        chk("t3_full", full, 1'b1);
        tick();
        chk("t3_ovf_once", ovf, 1'b0);
        chk("t3_nd_blocked", nd, 1'b0);
        // write while full on the same edge as the first pop
        tb_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("t4_ovf_full_pop", ovf, 1'b1);
        chk("t4_count15", count, 15);
        chk("t4_nd", nd, 1'b1);
        chk("t4_txd", txd, 8'h20);
        tick();
        chk("t4_ovf_clear", ovf, 1'b0);
        wait_drain(2000);
        chk("t3_frames", rx_n - base, 16);

        // write and pop on the same edge at count 5
        tb_busy = 1'b1;
        burst(8'h60, 5, 1'b1);
        chk("t4_count5", count, 5);
        tb_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h65;
        tick();
        wr_en = 1'b0;
        exp_q.push_back(8'h65);
        chk("t4_count_same", count, 5);
        chk("t4_nd2", nd, 1'b1);
        chk("t4_txd2", txd, 8'h60);
        wait_drain(1000);

        // wrap-around with varied bursts
        do_reset();
        base = rx_n;
        wr_cnt = 0;
        pop_cnt = 0;
        mon_cnt_en = 1'b1;
        v = 8'h80;
        foreach (sizes[i]) begin
            room = 0;
            while (count > 8 && room < 1000) begin
                tick();
                room++;
            end
            chk("t5_room", count <= 8, 1'b1);
            burst(v, sizes[i], 1'b1);
            v = 8'(v + sizes[i]);
            repeat (3 + i) tick();
        end
        wait_drain(3000);
        mon_cnt_en = 1'b0;
        chk("t5_frames", rx_n - base, 40);

        // reset while in HOLD with bytes queued
        do_reset();
        tb_busy = 1'b1;
        burst(8'hC0, 8, 1'b0);
        chk("t6_count8", count, 8);
        tb_busy = 1'b0;
        tick();
        chk("t6_count7", count, 7);
        chk("t6_nd_hold", nd, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_count0", count, 0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_nd0", nd, 1'b0);
        chk("t6_txd0", txd, 8'h00);
        chk("t6_ovf0", ovf, 1'b0);
        base = rx_n;
        burst(8'h3C, 1, 1'b1);
        wait_drain(500);
        chk("t6_frames", rx_n - base, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avr_tx_fifo.md
Name: avr_tx_fifo

Overview:
- Byte queue placed directly upstream of the AVR serial transmitter.
- Decouples bursty producers from the serial line: absorbs writes, then drains one byte at a time into the transmitter using its `new_data`/`busy` handshake.
- Guarantees that every handed-off byte is taken by the transmitter.

Parameters:
- ADDR_WIDTH, 4, log2 of FIFO depth; depth = 2^ADDR_WIDTH bytes (16 by default).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; byte accepted on this edge when full is low.
- wr_data  input  8  byte to enqueue.
- full  output  1  high when count == 2^ADDR_WIDTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_WIDTH+1  number of bytes stored (not yet handed to the transmitter).
- overflow  output  1  one-cycle pulse, registered: wr_en asserted while full was high.
- tx_busy  input  1  transmitter busy (registered in the transmitter; rises one cycle after it samples new_data).
- tx_new_data  output  1  one-cycle pulse handing tx_data to the transmitter.
- tx_data  output  8  byte presented with tx_new_data; holds its value until the next pulse.

Behaviour:
- Reset (sync, rst=1 at edge):
  - rd_ptr, wr_ptr and count go to 0.
  - State goes to IDLE.
  - tx_new_data=0, tx_data=8'h00, overflow=0, empty=1, full=0.
  - Memory contents are don't-care.
  - Reset mid-drain discards all queued bytes. A pulse registered on the same edge as reset does not appear.
- Storage and pointers:
  - Storage is 2^ADDR_WIDTH x 8.
  - Pointers are ADDR_WIDTH bits and wrap naturally from 2^ADDR_WIDTH-1 to 0.
  - count is tracked explicitly and is the sole source of full and empty.
- Write:
  - If wr_en && !full: mem[wr_ptr] <= wr_data and wr_ptr++.
  - If wr_en && full: byte dropped, pointers unchanged, overflow=1 in the next cycle.
- Drain FSM, 2 states:
  - IDLE:
    - If !empty && !tx_busy: tx_data <= mem[rd_ptr], tx_new_data <= 1, rd_ptr++, go to HOLD.
    - Otherwise tx_new_data <= 0.
  - HOLD:
    - tx_new_data <= 0; unconditionally return to IDLE.
    - This cycle covers the one-cycle lag before the transmitter's busy rises, so a second pulse is never issued to an idle-looking but already committed transmitter.
  - Result: tx_new_data is never high in two consecutive cycles and only asserts in a cycle following one where tx_busy was sampled low.
- Count update each cycle: +1 on an accepted write, -1 on a pop (IDLE issuing), unchanged if both or neither occur.
- Simultaneous write and pop:
  - Both take effect.
  - full is evaluated on the pre-edge count, so a write while full is rejected even if a pop happens on the same edge.
  - When empty, a pop cannot occur, so there is no read/write hazard on the same address.
- Latency: a write into an empty FIFO with tx_busy=0 gives empty=0 one cycle later and tx_new_data=1 two cycles after the write edge.
- Throughput:
  - Limited by the transmitter: the next pop occurs in the first IDLE cycle with tx_busy low after the previous byte completes.
  - Back-to-back minimum spacing between pulses is 2 cycles.
- tx_busy held high (transmitter blocked): the FIFO only fills; the fill level is visible on count/full.
- overflow is never high for more than one cycle per rejected write.

Test Plan:
- Reset, then write 8'hA5 once with tx_busy=0 → empty=0 one cycle later; tx_new_data=1 for exactly one cycle with tx_data=8'hA5, 2 cycles after the write edge; count returns to 0.
- Connect a transmitter model (CLK_PER_BIT=4), burst-write 8'h01..8'h10 (16 bytes) in consecutive cycles → full=1 after the 16th write; the serial output shows 16 frames in order 01..10 with no drops or duplicates; empty=1 at the end.
- tx_busy held 1, write 17 bytes → count=16, full=1, overflow pulses once on the 17th write, tx_new_data stays 0; then release tx_busy → the first byte drains and count reaches 15 after the pop.
- With count=16, wr_en and a pop on the same edge → write rejected, overflow=1, count=15; with count=5, write and pop on the same edge → count stays 5.
- Wrap-around: write and drain 40 bytes in varied bursts → pointers wrap at least twice, output order is preserved, count always equals writes minus pops.
- Assert rst while count=7 and the FSM is in HOLD → next cycle count=0, empty=1, tx_new_data=0, tx_data=8'h00; a subsequent write of 8'h3C is delivered normally.
